// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle restoring divider.
//   div_state_e : FSM encodings (IDLE, CALC, DONE)
//   DIV_WIDTH   : default operand width
//   DIV_CNT_W   : iteration counter width for the default operand width
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/cla_32.sv
// WIDTH-bit adder with carry-in and carry-out.
//   i_a, i_b : addends
//   i_cin    : carry-in
//   o_sum    : WIDTH-bit sum
//   o_cout   : carry-out of the MSB
module cla_32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  // Extended by one bit so the carry-out falls out of the top of the sum.
  assign {o_cout, o_sum} = (WIDTH+1)'(i_a) + (WIDTH+1)'(i_b) + (WIDTH+1)'(i_cin);

endmodule

// File: rtl/sub_32.sv
// WIDTH-bit subtractor: a - b computed as a + ~b + 1 on the adder.
//   i_a, i_b : minuend, subtrahend
//   o_diff   : a - b modulo 2^WIDTH
//   o_cout   : 1 = no borrow (a >= b), 0 = borrow
module sub_32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_cout
);

  cla_32 #(.WIDTH(WIDTH)) u_cla (
    .i_a   (i_a),
    .i_b   (~i_b),
    .i_cin (1'b1),
    .o_sum (o_diff),
    .o_cout(o_cout)
  );

endmodule

// File: rtl/div_32.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU (quotient -> LO, remainder -> HI).
// One quotient bit per cycle, MSB first; start/done handshake.
//   clk, rst            : clock, synchronous active-high reset
//   start, sign         : request (accepted in IDLE only), 1 = signed
//   dividend, divisor   : operands, sampled with an accepted start
//   busy, done          : busy in CALC/DONE, done pulses for one cycle
//   div_zero            : divisor was zero, held until next accepted start
//   quotient, remainder : results, held until the next result is produced
// Build option: define DIV_SIGNED_EN to honour sign (abs/negate logic);
// without it every operation is unsigned and sign is ignored.
module div_32
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       r_state;
  div_state_e       w_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_partial;
  logic [WIDTH-1:0] w_trial;
  logic             w_no_borrow;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_q_nx;
  logic             w_div0;
  logic             w_last;

  assign w_div0 = (divisor == '0);
  assign w_last = (r_cnt == CNT_W'(WIDTH-1));

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_neg_q;
  logic w_neg_r;

  // Operand magnitudes; the most-negative value maps to its unsigned bit pattern.
  assign w_a_mag = (sign && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
  assign w_b_mag = (sign && divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;
  assign w_neg_q = sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
  assign w_neg_r = sign && dividend[WIDTH-1];
`else
  logic w_unused_sign;

  assign w_a_mag       = dividend;
  assign w_b_mag       = divisor;
  assign w_unused_sign = sign;
`endif

  // Trial subtract of the divisor from the shifted partial remainder.
  assign w_partial = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};

  sub_32 #(.WIDTH(WIDTH)) u_sub (
    .i_a   (w_partial),
    .i_b   (r_divisor),
    .o_diff(w_trial),
    .o_cout(w_no_borrow)
  );

  assign w_rem_nx = w_no_borrow ? w_trial : w_partial;
  assign w_q_nx   = {r_q[WIDTH-2:0], w_no_borrow};

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_div0 ? DONE : CALC;
      CALC:    if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_q       <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_SIGNED_EN
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      busy    <= (w_next != IDLE);
      done    <= (w_next == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            div_zero <= w_div0;
            if (w_div0) begin
              // Divide-by-zero bypasses CALC and the sign fixup.
              quotient  <= '1;
              remainder <= dividend;
            end else begin
              r_q       <= w_a_mag;
              r_rem     <= '0;
              r_divisor <= w_b_mag;
              r_cnt     <= '0;
`ifdef DIV_SIGNED_EN
              r_neg_q   <= w_neg_q;
              r_neg_r   <= w_neg_r;
`endif
            end
          end
        end
        CALC: begin
          r_q   <= w_q_nx;
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
`ifdef DIV_SIGNED_EN
            quotient  <= r_neg_q ? (~w_q_nx + WIDTH'(1))   : w_q_nx;
            remainder <= r_neg_r ? (~w_rem_nx + WIDTH'(1)) : w_rem_nx;
`else
            quotient  <= w_q_nx;
            remainder <= w_rem_nx;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32.sv
// Self-checking bench for div_32: randomized and directed divisions checked
// by a scoreboard against a plain-arithmetic reference model.
module tb_div_32;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sign;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           cyc0;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  div_32 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sign     (sign),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .quotient (quotient),
    .remainder(remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned or truncating signed division on 64-bit integers.
  function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    longint sa;
    longint sb;
    logic   use_s;
    use_s = 1'b0;
`ifdef DIV_SIGNED_EN
    use_s = s;
`endif
    dz = (b == 0);
    if (dz) begin
      q = '1;
      r = a;
      return;
    end
    if (use_s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = W'(sa / sb);
    r = W'(sa % sb);
  endfunction

  task automatic wait_idle();
    int t = 0;
    while ((busy || done) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%b done=%b after %0d cycles, expected idle", busy, done, t);
    end
  endtask

  // Called at a negedge; the following posedge is the start edge.
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    wait_idle();
    model(s, a, b, e.q, e.r, e.dz);
    e.cyc0   = cyc + 1;
    sb_q.push_back(e);
    start    = 1'b1;
    sign     = s;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    sign     = 1'($urandom);
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Monitor: every done pulse is checked against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no pending operation");
      end else begin
        e = sb_q.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_zero", W'(div_zero), W'(e.dz));
        chk("busy_at_done", W'(busy), W'(1));
        chk("latency", W'(cyc - e.cyc0 + 1), e.dz ? W'(1) : W'(W + 1));
      end
    end
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int t;
    rst      = 1'b1;
    start    = 1'b0;
    sign     = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_div_zero", W'(div_zero), W'(0));
    chk("rst_quotient", quotient, W'(0));
    chk("rst_remainder", remainder, W'(0));
    rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 32'd100, 32'd7);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1);
    issue(1'b0, 32'd5, 32'd0);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(1'b1, 32'h8000_0000, 32'd0);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE);
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(1'b0, 32'd3, 32'd9);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = a >> $urandom_range(0, 31);
        3:       b = -W'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      issue(1'($urandom), a, b);
    end

    // Start while busy is ignored and operands are not resampled.
    issue(1'b0, 32'd9, 32'd3);
    repeat (9) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(negedge clk);
    start    = 1'b0;
    wait_idle();

    // Reset mid-CALC abandons the operation.
    @(negedge clk);
    start    = 1'b1;
    sign     = 1'b0;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(negedge clk);
    start    = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_done", W'(done), W'(0));
    chk("midrst_quotient", quotient, W'(0));
    chk("midrst_remainder", remainder, W'(0));
    chk("midrst_div_zero", W'(div_zero), W'(0));
    rst = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'd50, 32'd5);

    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
